dpram_be_init: RTL and testbench

Parametrised true dual-port RAM with per-byte write enables and a single shared clock. It is the generalised successor to the fixed 16-bit/512-word byte-select dual-port RAM. It adds configurable width, depth, read latency and read-during-write mode. It also adds a hardware init sweep after reset, read-valid strobes and write-write collision detection. It sits as the on-chip buffer between two independent bus masters in the SoC fabric.

---
 rtl/dpram_be_init.sv | 136 +++++++++++++
 tb/tb_dpram_be_init.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be_init.sv
// dpram_be_init: true dual-port byte-enable RAM with init sweep, read-valid strobes and collision flag
module dpram_be_init #(
    parameter int ADDR_W = 9,
    parameter int BYTE_W = 8,
    parameter int LANES = 2,
    parameter int RD_LAT = 1,
    parameter int RDW_MODE = 0,
    parameter logic [LANES*BYTE_W-1:0] INIT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,
    output logic                    collision,
    input  logic [ADDR_W-1:0]       a_addr,
    input  logic [LANES-1:0]        a_sel,
    input  logic                    a_we,
    input  logic                    a_ce,
    input  logic [LANES*BYTE_W-1:0] a_write,
    output logic [LANES*BYTE_W-1:0] a_read,
    output logic                    a_valid,
    input  logic [ADDR_W-1:0]       b_addr,
    input  logic [LANES-1:0]        b_sel,
    input  logic                    b_we,
    input  logic                    b_ce,
    input  logic [LANES*BYTE_W-1:0] b_write,
    output logic [LANES*BYTE_W-1:0] b_read,
    output logic                    b_valid
);
    localparam int DATA_W = LANES * BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, READY} state_e;

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           cnt_q, cnt_d;
    logic                        collision_q, collision_d;
    logic                        ready;
    logic [1:0][ADDR_W-1:0]      addr;
    logic [1:0][LANES-1:0]       sel;
    logic [1:0]                  we, ce, wr, vld;
    logic [1:0][DATA_W-1:0]      wdata, rd;
    logic [DATA_W-1:0]           mem [DEPTH];

    assign ready = state_q == READY;
    assign addr = {b_addr, a_addr};
    assign sel = {b_sel, a_sel};
    assign we = {b_we, a_we};
    assign ce = {b_ce, a_ce};
    assign wdata = {b_write, a_write};
    assign wr = ce & we & {2{ready}};

    // sweep counter walks every address once, then the FSM parks in READY
    always_comb begin
        state_d = (state_q == INIT && &cnt_q) ? READY : state_q;
        cnt_d = (state_q == INIT) ? cnt_q + 1'b1 : cnt_q;
        collision_d = &wr && addr[0] == addr[1] && |(sel[0] & sel[1]);
    end

    // control state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            collision_q <= collision_d;
        end
    end

    // array update: sweep during INIT; afterwards B lanes first so A wins overlapping lanes
    always_ff @(posedge clk) begin
        if (!ready)
            mem[cnt_q] <= INIT_VAL;
        else
            for (int p = 1; p >= 0; p--)
                for (int i = 0; i < LANES; i++)
                    if (wr[p] && sel[p][i])
                        mem[addr[p]][i*BYTE_W +: BYTE_W] <= wdata[p][i*BYTE_W +: BYTE_W];
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_W-1:0] rd_d, rd1_q;
        logic              v1_q;

        // read word; in write-first mode this port's own selected lanes are bypassed in
        always_comb begin
            rd_d = mem[addr[p]];
            for (int i = 0; i < LANES; i++)
                if (RDW_MODE == 1 && wr[p] && sel[p][i])
                    rd_d[i*BYTE_W +: BYTE_W] = wdata[p][i*BYTE_W +: BYTE_W];
        end

        // first read stage: captures on every READY access, holds otherwise
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd1_q <= '0;
                v1_q <= 1'b0;
            end else begin
                v1_q <= ready & ce[p];
                if (ready && ce[p])
                    rd1_q <= rd_d;
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd2_q;
            logic              v2_q;

            // optional output stage; valid travels with data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd2_q <= '0;
                    v2_q <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q)
                        rd2_q <= rd1_q;
                end
            end
            assign rd[p] = rd2_q;
            assign vld[p] = v2_q;
        end else begin : g_lat1
            assign rd[p] = rd1_q;
            assign vld[p] = v1_q;
        end
    end

    assign init_done = ready;
    assign collision = collision_q;
    assign a_read = rd[0];
    assign b_read = rd[1];
    assign a_valid = vld[0];
    assign b_valid = vld[1];
endmodule

// File: tb/tb_dpram_be_init.sv
// tb_dpram_be_init: directed checks of the byte-enable dual-port RAM (default and RD_LAT=2/write-first builds)
module tb_dpram_be_init;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  a_addr = '0, b_addr = '0;
    logic [1:0]  a_sel = '0, b_sel = '0, c_sel = '0;
    logic        a_we = 1'b0, a_ce = 1'b0, b_we = 1'b0, b_ce = 1'b0, c_we = 1'b0, c_ce = 1'b0;
    logic [15:0] a_write = '0, b_write = '0, c_write = '0;
    logic [3:0]  c_addr = '0;
    logic [15:0] a_read, b_read, c_read, d_read;
    logic        a_valid, b_valid, c_valid, d_valid;
    logic        init_done, collision, init_done2, collision2;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    dpram_be_init dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .collision(collision),
        .a_addr(a_addr), .a_sel(a_sel), .a_we(a_we), .a_ce(a_ce), .a_write(a_write),
        .a_read(a_read), .a_valid(a_valid),
        .b_addr(b_addr), .b_sel(b_sel), .b_we(b_we), .b_ce(b_ce), .b_write(b_write),
        .b_read(b_read), .b_valid(b_valid)
    );

    dpram_be_init #(.ADDR_W(4), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(16'h5A5A)) dut2 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done2), .collision(collision2),
        .a_addr(c_addr), .a_sel(c_sel), .a_we(c_we), .a_ce(c_ce), .a_write(c_write),
        .a_read(c_read), .a_valid(c_valid),
        .b_addr(4'h0), .b_sel(2'b00), .b_we(1'b0), .b_ce(1'b0), .b_write(16'h0000),
        .b_read(d_read), .b_valid(d_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic ce, input logic we, input logic [1:0] sel, input logic [8:0] adr, input logic [15:0] d);
        a_ce = ce; a_we = we; a_sel = sel; a_addr = adr; a_write = d;
    endtask

    task automatic set_b(input logic ce, input logic we, input logic [1:0] sel, input logic [8:0] adr, input logic [15:0] d);
        b_ce = ce; b_we = we; b_sel = sel; b_addr = adr; b_write = d;
    endtask

    task automatic set_c(input logic ce, input logic we, input logic [1:0] sel, input logic [3:0] adr, input logic [15:0] d);
        c_ce = ce; c_we = we; c_sel = sel; c_addr = adr; c_write = d;
    endtask

    initial begin
        int  n;
        logic seen;
        repeat (3) step();
        check("rst_init_done", init_done, 0);
        check("rst_collision", collision, 0);
        check("rst_a_read", a_read, 0);
        check("rst_b_read", b_read, 0);
        check("rst_valid", {a_valid, b_valid, c_valid}, 0);
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 600) begin
            step();
            n++;
            if (n == 16) check("init_done2_16", init_done2, 1);
        end
        check("init_edges", n, 512);
        check("ready_no_valid", a_valid, 0);

        set_a(1, 0, 2'b00, 9'h1FF, 0);
        step();
        set_a(0, 0, 2'b00, 0, 0);
        check("t1_read", a_read, 16'h0000);
        check("t1_valid", a_valid, 1);
        step();
        check("t1_valid_pulse", a_valid, 0);

        set_a(1, 1, 2'b11, 9'd5, 16'h1234);
        step();
        set_a(1, 1, 2'b10, 9'd5, 16'hAB00);
        step();
        check("t2_read_first", a_read, 16'h1234);
        set_a(0, 0, 2'b00, 0, 0);
        set_b(1, 0, 2'b00, 9'd5, 0);
        step();
        set_b(0, 0, 2'b00, 0, 0);
        check("t2_b_read", b_read, 16'hAB34);
        check("t2_b_valid", b_valid, 1);
        step();
        check("t2_b_hold", b_read, 16'hAB34);

        set_a(1, 1, 2'b11, 9'd7, 16'h1111);
        step();
        set_a(1, 1, 2'b11, 9'd7, 16'h2222);
        set_b(1, 0, 2'b00, 9'd7, 0);
        step();
        check("t3_a_rdw", a_read, 16'h1111);
        check("t3_b_cross", b_read, 16'h1111);
        set_a(0, 0, 2'b00, 0, 0);
        step();
        check("t3_b_new", b_read, 16'h2222);
        set_b(0, 0, 2'b00, 0, 0);

        set_a(1, 1, 2'b01, 9'd3, 16'h00FF);
        set_b(1, 1, 2'b11, 9'd3, 16'hEEEE);
        step();
        set_a(0, 0, 2'b00, 0, 0);
        set_b(0, 0, 2'b00, 0, 0);
        check("t4_collision", collision, 1);
        step();
        check("t4_coll_pulse", collision, 0);
        set_a(1, 0, 2'b00, 9'd3, 0);
        step();
        check("t4_merge", a_read, 16'hEEFF);
        set_a(1, 1, 2'b01, 9'd3, 16'h0011);
        set_b(1, 1, 2'b10, 9'd3, 16'h2200);
        step();
        set_a(1, 1, 2'b11, 9'd8, 16'h1);
        set_b(1, 1, 2'b11, 9'd9, 16'h2);
        step();
        check("t4_no_coll_lanes", collision, 0);
        set_a(1, 0, 2'b00, 9'd3, 0);
        set_b(0, 0, 2'b00, 0, 0);
        step();
        check("t4_no_coll_addr", collision, 0);
        check("t4_disjoint", a_read, 16'h2211);
        set_a(0, 0, 2'b00, 0, 0);

        set_c(1, 0, 2'b00, 4'd0, 0);
        step();
        set_c(0, 0, 2'b00, 0, 0);
        check("t6_lat2_v0", c_valid, 0);
        step();
        check("t6_init_val", c_read, 16'h5A5A);
        check("t6_lat2_v1", c_valid, 1);
        set_c(1, 1, 2'b11, 4'd0, 16'h0A0A);
        step();
        set_c(1, 1, 2'b11, 4'd1, 16'h0B0B);
        step();
        set_c(1, 1, 2'b11, 4'd2, 16'h0C0C);
        step();
        set_c(0, 0, 2'b00, 0, 0);
        step();
        set_c(1, 0, 2'b00, 4'd0, 0);
        step();
        check("t6_first_v", c_valid, 0);
        set_c(1, 0, 2'b00, 4'd1, 0);
        step();
        check("t6_d0", c_read, 16'h0A0A);
        check("t6_v0", c_valid, 1);
        set_c(1, 0, 2'b00, 4'd2, 0);
        step();
        check("t6_d1", c_read, 16'h0B0B);
        check("t6_v1", c_valid, 1);
        set_c(0, 0, 2'b00, 0, 0);
        step();
        check("t6_d2", c_read, 16'h0C0C);
        check("t6_v2", c_valid, 1);
        step();
        check("t6_v_end", c_valid, 0);
        check("t6_hold", c_read, 16'h0C0C);

        set_c(1, 1, 2'b11, 4'd3, 16'h1111);
        step();
        set_c(1, 1, 2'b01, 4'd3, 16'h2222);
        step();
        set_c(0, 0, 2'b00, 0, 0);
        step();
        check("t3_write_first", c_read, 16'h1122);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (100) step();
        rst_n = 1'b0;
        #1;
        check("t5_rst_done", init_done, 0);
        check("t5_rst_valid", a_valid, 0);
        step();
        rst_n = 1'b1;
        set_a(1, 1, 2'b11, 9'd5, 16'hBEEF);
        n = 0;
        seen = 1'b0;
        while (!init_done && n < 600) begin
            step();
            n++;
            if (a_valid) seen = 1'b1;
        end
        set_a(0, 0, 2'b00, 0, 0);
        check("t5_init_edges", n, 512);
        check("t5_no_valid", seen, 0);
        set_a(1, 0, 2'b00, 9'd5, 0);
        step();
        set_a(0, 0, 2'b00, 0, 0);
        check("t5_ignored_write", a_read, 16'h0000);
        check("t5_valid", a_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
